// File: rtl/eth_rx_desc_pkg.sv
// Shared register map, descriptor layout and helpers for the Ethernet RX descriptor ring.
package eth_rx_desc_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_POP     = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_TIMEOUT = 3'd3;
    localparam logic [2:0] REG_DROPS   = 3'd4;

    localparam int unsigned DESC_VALID_BIT   = 31;
    localparam int unsigned DESC_ERR_BIT     = 30;
    localparam int unsigned STATUS_FULL_BIT  = 8;
    localparam int unsigned STATUS_EMPTY_BIT = 9;

    // Storage width for the length field; LEN_W of the ring must not exceed it.
    localparam int unsigned DESC_LEN_W = 16;

    typedef struct packed {
        logic                  err;
        logic [DESC_LEN_W-1:0] len;
    } rx_desc_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_rx_desc_fifo.sv
// One receive channel: descriptor storage, wrapping pointers, occupancy count and
// the coalescing age timer.
module eth_rx_desc_fifo
    import eth_rx_desc_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned TMR_W = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  rx_desc_t         desc_in,
    output rx_desc_t         head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [TMR_W-1:0] timer,
    output logic             drop
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    rx_desc_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= desc_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            timer  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
            if (empty || do_pop)  timer <= '0;
            else if (timer != '1) timer <= timer + TMR_W'(1);
        end
    end

endmodule

// File: rtl/eth_rx_desc_ring.sv
// Multi-channel RX descriptor ring with register access, drop counting and
// threshold/timeout interrupt coalescing.
module eth_rx_desc_ring
    import eth_rx_desc_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned LEN_W      = 11,
    parameter int unsigned TMR_W      = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    input  logic [NUM_CH-1:0]       frm_valid_i,
    input  logic [NUM_CH*LEN_W-1:0] frm_len_i,
    input  logic [NUM_CH-1:0]       frm_err_i,
    output logic [NUM_CH-1:0]       frm_full_o,
    output logic                    irq_o
);
    localparam int unsigned WORD_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [2:0]            sel_ch;
    logic [2:0]            sel_reg;
    logic                  ch_ok;
    logic                  rd_en;
    logic                  wr_en;
    logic [NUM_CH-1:0]     ch_event;
    logic [31:0]           word_chain [NUM_CH+1];
    logic                  unused_bits;

    assign word_idx      = addr_i >> WORD_SHIFT;
    assign sel_ch        = word_idx[5:3];
    assign sel_reg       = word_idx[2:0];
    assign ch_ok         = (32'(sel_ch) < NUM_CH);
    assign rd_en         = req_i & ~we_i & ch_ok;
    assign wr_en         = req_i & we_i & ch_ok;
    assign unused_bits   = ^{word_idx, data_i, be_i};
    assign word_chain[0] = '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             hit;
        logic             pop;
        logic             drop;
        logic             full;
        logic             empty;
        logic [CNT_W-1:0] count;
        logic [TMR_W-1:0] timer;
        rx_desc_t         head;
        rx_desc_t         desc;
        logic             irq_en;
        logic [7:0]       thr;
        logic [7:0]       eff_thr;
        logic [TMR_W-1:0] tmo;
        logic [15:0]      drops;
        logic [31:0]      reg_img;

        assign hit  = (sel_ch == 3'(c));
        assign pop  = rd_en & hit & (sel_reg == REG_POP);
        assign desc = '{err: frm_err_i[c], len: DESC_LEN_W'(frm_len_i[c*LEN_W +: LEN_W])};

        eth_rx_desc_fifo #(
            .DEPTH (DEPTH),
            .TMR_W (TMR_W)
        ) u_fifo (
            .clk     (clk_i),
            .rst_n   (rst_ni),
            .push    (frm_valid_i[c]),
            .pop     (pop),
            .desc_in (desc),
            .head    (head),
            .count   (count),
            .full    (full),
            .empty   (empty),
            .timer   (timer),
            .drop    (drop)
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                irq_en <= 1'b0;
                thr    <= '0;
                tmo    <= '0;
                drops  <= '0;
            end else begin
                if (wr_en && hit && sel_reg == REG_CTRL) begin
                    if (be_i[0]) irq_en <= data_i[0];
                    if (be_i[1]) thr    <= data_i[15:8];
                end
                if (wr_en && hit && sel_reg == REG_TIMEOUT)
                    tmo <= TMR_W'(be_merge(32'(tmo), data_i[31:0], be_i[3:0]));
                // A drop landing on the clearing read is kept as the first new count.
                if (rd_en && hit && sel_reg == REG_DROPS) drops <= drop ? 16'd1 : 16'd0;
                else if (drop && drops != '1)            drops <= drops + 16'd1;
            end
        end

        always_comb begin
            reg_img = '0;
            case (sel_reg)
                REG_STATUS: begin
                    reg_img[7:0]              = 8'(count);
                    reg_img[STATUS_FULL_BIT]  = full;
                    reg_img[STATUS_EMPTY_BIT] = empty;
                end
                REG_POP: begin
                    if (!empty) begin
                        reg_img[DESC_LEN_W-1:0] = head.len;
                        reg_img[DESC_ERR_BIT]   = head.err;
                        reg_img[DESC_VALID_BIT] = 1'b1;
                    end
                end
                REG_CTRL: begin
                    reg_img[0]    = irq_en;
                    reg_img[15:8] = thr;
                end
                REG_TIMEOUT: reg_img = 32'(tmo);
                REG_DROPS:   reg_img = {16'd0, drops};
                default:     reg_img = '0;
            endcase
        end

        assign word_chain[c+1] = word_chain[c] | (hit ? reg_img : 32'd0);
        assign eff_thr         = (thr == '0) ? 8'd1 : thr;
        assign ch_event[c]     = irq_en & ~empty &
                                 ((32'(count) >= 32'(eff_thr)) | ((tmo != '0) & (timer >= tmo)));
        assign frm_full_o[c]   = full;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o <= '0;
            irq_o  <= 1'b0;
        end else begin
            if (req_i && !we_i) data_o <= ch_ok ? DATA_WIDTH'(word_chain[NUM_CH]) : '0;
            irq_o <= |ch_event;
        end
    end

endmodule

// File: tb/tb_eth_rx_desc_ring.sv
// Directed self-checking bench for eth_rx_desc_ring with default parameters.
module tb_eth_rx_desc_ring;
    import eth_rx_desc_pkg::*;

    localparam int unsigned NUM_CH     = 2;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 15;
    localparam int unsigned LEN_W      = 11;
    localparam int unsigned TMR_W      = 16;
    localparam int unsigned LW_ALL     = NUM_CH * LEN_W;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    req_i = 1'b0;
    logic                    we_i = 1'b0;
    logic [ADDR_WIDTH-1:0]   addr_i = '0;
    logic [DATA_WIDTH/8-1:0] be_i = '0;
    logic [DATA_WIDTH-1:0]   data_i = '0;
    logic [DATA_WIDTH-1:0]   data_o;
    logic [NUM_CH-1:0]       frm_valid_i = '0;
    logic [LW_ALL-1:0]       frm_len_i = '0;
    logic [NUM_CH-1:0]       frm_err_i = '0;
    logic [NUM_CH-1:0]       frm_full_o;
    logic                    irq_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    eth_rx_desc_ring #(
        .NUM_CH     (NUM_CH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_W      (LEN_W),
        .TMR_W      (TMR_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .be_i        (be_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .frm_valid_i (frm_valid_i),
        .frm_len_i   (frm_len_i),
        .frm_err_i   (frm_err_i),
        .frm_full_o  (frm_full_o),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input int unsigned ch, input int unsigned r);
        return ADDR_WIDTH'(((ch << 3) | r) << 3);
    endfunction

    task automatic reg_write(input int unsigned ch, input int unsigned r,
                             input logic [31:0] val, input logic [7:0] be);
        @(negedge clk_i);
        req_i  = 1'b1;
        we_i   = 1'b1;
        addr_i = reg_addr(ch, r);
        be_i   = be;
        data_i = 64'(val);
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic reg_read(input int unsigned ch, input int unsigned r, output logic [63:0] val);
        @(negedge clk_i);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = reg_addr(ch, r);
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        val   = data_o;
    endtask

    task automatic push(input int unsigned ch, input int unsigned len, input logic err);
        @(negedge clk_i);
        frm_valid_i = NUM_CH'(1) << ch;
        frm_len_i   = LW_ALL'(len) << (ch * LEN_W);
        frm_err_i   = err ? (NUM_CH'(1) << ch) : '0;
        @(posedge clk_i);
        #1;
        frm_valid_i = '0;
        frm_err_i   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        int unsigned cycles;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_irq", 64'(irq_o), 0);
        check("rst_data", data_o, 0);
        check("rst_full", 64'(frm_full_o), 0);
        rst_ni = 1'b1;
        reg_read(0, REG_STATUS, rd);
        check("rst_status", rd, 64'h200);

        // Three frames below threshold, drained in order, then empty pop
        reg_write(0, REG_CTRL, 32'h0401, 8'hFF);
        push(0, 64, 1'b0);
        push(0, 128, 1'b0);
        push(0, 1518, 1'b1);
        @(posedge clk_i);
        #1;
        check("thr4_noirq", 64'(irq_o), 0);
        reg_read(0, REG_STATUS, rd);
        check("status3", rd, 64'h003);
        reg_read(0, REG_POP, rd);
        check("pop0", rd, 64'h80000040);
        reg_read(0, REG_POP, rd);
        check("pop1", rd, 64'h80000080);
        reg_read(0, REG_POP, rd);
        check("pop2", rd, 64'hC00005EE);
        reg_read(0, REG_POP, rd);
        check("pop_empty", rd, 64'h0);
        reg_read(0, REG_STATUS, rd);
        check("status_after_empty_pop", rd, 64'h200);
        reg_write(0, REG_CTRL, 32'h0, 8'hFF);

        // Threshold interrupt on channel 1
        reg_write(1, REG_CTRL, 32'h0201, 8'hFF);
        push(1, 60, 1'b0);
        check("thr2_one", 64'(irq_o), 0);
        push(1, 61, 1'b0);
        check("thr2_same_cycle", 64'(irq_o), 0);
        @(posedge clk_i);
        #1;
        check("thr2_irq", 64'(irq_o), 1);
        reg_read(1, REG_POP, rd);
        check("thr2_pop", rd, 64'h8000003C);
        check("thr2_irq_hold", 64'(irq_o), 1);
        @(posedge clk_i);
        #1;
        check("thr2_irq_drop", 64'(irq_o), 0);
        reg_read(1, REG_POP, rd);
        check("thr2_pop2", rd, 64'h8000003D);
        reg_write(1, REG_CTRL, 32'h0, 8'hFF);

        // Timeout interrupt on channel 0
        reg_write(0, REG_CTRL, 32'h0801, 8'hFF);
        reg_write(0, REG_TIMEOUT, 32'd100, 8'hFF);
        reg_read(0, REG_TIMEOUT, rd);
        check("tmo_readback", rd, 64'd100);
        push(0, 256, 1'b0);
        cycles = 0;
        while (irq_o !== 1'b1 && cycles < 200) begin
            @(posedge clk_i);
            #1;
            cycles++;
        end
        check("tmo_rise_window", 64'(cycles >= 101 && cycles <= 102), 1);
        reg_read(0, REG_POP, rd);
        check("tmo_pop", rd, 64'h80000100);
        @(posedge clk_i);
        #1;
        check("tmo_irq_drop", 64'(irq_o), 0);
        reg_write(0, REG_CTRL, 32'h0, 8'hFF);
        reg_write(0, REG_TIMEOUT, 32'h0, 8'hFF);

        // Overflow: 18 pushes into 16 slots
        for (int unsigned i = 1; i <= 18; i++) push(0, i, 1'b0);
        check("full_flag", 64'(frm_full_o), 64'b01);
        reg_read(0, REG_STATUS, rd);
        check("status_full", rd, 64'h110);
        reg_read(0, REG_DROPS, rd);
        check("drops2", rd, 64'd2);
        reg_read(0, REG_DROPS, rd);
        check("drops_cleared", rd, 64'd0);

        // Drop coinciding with the clearing read
        @(negedge clk_i);
        frm_valid_i = 2'b01;
        frm_len_i   = LW_ALL'(999);
        req_i       = 1'b1;
        we_i        = 1'b0;
        addr_i      = reg_addr(0, REG_DROPS);
        @(posedge clk_i);
        #1;
        frm_valid_i = '0;
        req_i       = 1'b0;
        check("drops_clr_race_old", data_o, 64'd0);
        reg_read(0, REG_DROPS, rd);
        check("drops_clr_race_new", rd, 64'd1);

        // Push and pop in the same cycle on a full ring
        @(negedge clk_i);
        frm_valid_i = 2'b01;
        frm_len_i   = LW_ALL'(100);
        req_i       = 1'b1;
        we_i        = 1'b0;
        addr_i      = reg_addr(0, REG_POP);
        @(posedge clk_i);
        #1;
        frm_valid_i = '0;
        req_i       = 1'b0;
        check("full_pushpop_data", data_o, 64'h80000001);
        reg_read(0, REG_STATUS, rd);
        check("full_pushpop_status", rd, 64'h110);
        reg_read(0, REG_DROPS, rd);
        check("full_pushpop_drops", rd, 64'd0);
        for (int unsigned i = 2; i <= 16; i++) begin
            reg_read(0, REG_POP, rd);
            check("order", rd, 64'h80000000 | 64'(i));
        end
        reg_read(0, REG_POP, rd);
        check("order_last", rd, 64'h80000064);
        check("drained_full", 64'(frm_full_o), 0);

        // Reset with descriptors stored
        reg_write(1, REG_CTRL, 32'h0101, 8'hFF);
        for (int unsigned i = 0; i < 5; i++) push(1, 200 + i, 1'b0);
        reg_read(1, REG_STATUS, rd);
        check("pre_rst_status", rd, 64'h005);
        check("pre_rst_irq", 64'(irq_o), 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("rst_async_irq", 64'(irq_o), 0);
        check("rst_async_data", data_o, 0);
        push(1, 7, 1'b0);
        push(0, 7, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        reg_read(1, REG_STATUS, rd);
        check("post_rst_status1", rd, 64'h200);
        reg_read(0, REG_STATUS, rd);
        check("post_rst_status0", rd, 64'h200);
        reg_read(1, REG_CTRL, rd);
        check("post_rst_ctrl", rd, 64'h0);
        check("post_rst_irq", 64'(irq_o), 0);

        // Byte enables and out-of-range channel
        reg_write(1, REG_TIMEOUT, 32'h1234, 8'h01);
        reg_write(1, REG_TIMEOUT, 32'hAB00, 8'h02);
        reg_read(1, REG_TIMEOUT, rd);
        check("be_timeout", rd, 64'hAB34);
        reg_write(1, REG_CTRL, 32'h0301, 8'h02);
        reg_read(1, REG_CTRL, rd);
        check("be_ctrl", rd, 64'h0300);
        reg_write(2, REG_CTRL, 32'h0301, 8'hFF);
        reg_read(2, REG_CTRL, rd);
        check("bad_ch_ctrl", rd, 64'h0);
        reg_read(2, REG_STATUS, rd);
        check("bad_ch_status", rd, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_rx_desc_ring.md
ETH_RX_DESC_RING -- requirements
Module: eth_rx_desc_ring

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent receive channels (1..8).
REQ-002 SHALL have parameter DEPTH, default 16, descriptor slots per channel (power of two, >=2).
REQ-003 SHALL have parameter DATA_WIDTH, default 64, register bus width (32 or 64).
REQ-004 SHALL have parameter ADDR_WIDTH, default 15, register bus byte-address width.
REQ-005 SHALL have parameter LEN_W, default 11, frame length field width.
REQ-006 SHALL have parameter TMR_W, default 16, coalescing timer width.
REQ-007 SHALL have ports: clk_i input 1 system clock; rst_ni input 1 asynchronous active-low reset.
REQ-008 SHALL have ports: req_i input 1 access strobe; we_i input 1 write; addr_i input ADDR_WIDTH byte address; be_i input DATA_WIDTH/8 byte enables; data_i input DATA_WIDTH write data; data_o output DATA_WIDTH read data.
REQ-009 SHALL have ports: frm_valid_i input NUM_CH frame-done pulse per channel; frm_len_i input NUM_CH*LEN_W lengths; frm_err_i input NUM_CH error flags; frm_full_o output NUM_CH ring-full status.
REQ-010 SHALL have port irq_o output 1 coalesced interrupt.

Function
REQ-011 SHALL decode word index = addr_i >> log2(DATA_WIDTH/8); channel = index[5:3]; register = index[2:0]; channel >= NUM_CH reads 0, writes ignored.
REQ-012 SHALL implement registers: 0 STATUS (RO: [7:0] count, bit8 full, bit9 empty), 1 POP (RO, destructive), 2 CTRL (RW: bit0 irq_en, [15:8] threshold), 3 TIMEOUT (RW, [TMR_W-1:0]), 4 DROPS (RO, saturating 16-bit, cleared on read).
REQ-013 SHALL return read data on data_o exactly one cycle after req_i&!we_i; data_o SHALL hold its value otherwise.
REQ-014 SHALL apply writes in the req_i&we_i cycle, per byte under be_i.
REQ-015 SHALL push descriptor {err, len} into the channel FIFO on frm_valid_i when not full, no backpressure.
REQ-016 SHALL, on frm_valid_i while full, discard the descriptor and increment DROPS (saturate at 0xFFFF).
REQ-017 SHALL, on POP read when not empty, return {bit31 valid=1, bit30 err, [LEN_W-1:0] len} and advance head; when empty, return 0 and change no state.
REQ-018 SHALL handle simultaneous push and pop on one channel: both occur, count unchanged; push when full with simultaneous pop is accepted.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-020 SHALL drive frm_full_o[c] = (count==DEPTH), combinational from registered state.
REQ-021 SHALL keep per-channel timer: cleared when count==0 or on pop; else increments, saturating at all-ones.
REQ-022 SHALL assert channel event when irq_en & count!=0 & (count>=max(threshold,1) | (TIMEOUT!=0 & timer>=TIMEOUT)).
REQ-023 SHALL register irq_o = OR of channel events, one cycle latency; level-sensitive, drops when condition clears.
REQ-024 SHALL treat DROPS clear-on-read and a simultaneous drop: result 1.

Reset
REQ-025 SHALL, on rst_ni low, asynchronously clear pointers, counts, timers, DROPS, CTRL, TIMEOUT, data_o=0, irq_o=0.
REQ-026 SHALL discard stored descriptors on reset mid-operation; frm_valid_i during reset ignored.

Structure
REQ-027 SHALL place register offsets, descriptor bit positions and the descriptor typedef in package eth_rx_desc_pkg.
REQ-028 SHALL instantiate sub-module eth_rx_desc_fifo (one per channel: storage, pointers, count, timer).

Verification
REQ-029 Push 3 frames ch0 (len 64,128,1518 err=1 last), threshold 4 -> no irq; 4 POP reads -> 0x80000040, 0x80000080, 0xC00005EE, 0x0.
REQ-030 irq_en=1, threshold 2, push 2 frames ch1 -> irq_o high cycle after 2nd push; one POP -> irq_o low next cycle.
REQ-031 threshold 8, TIMEOUT 100, one push ch0 -> irq_o rises 101-102 cycles later; POP -> low.
REQ-032 Push 18 frames ch0 (DEPTH 16) -> frm_full_o[0]=1, DROPS reads 2, then reads 0.
REQ-033 Full ring, push and POP same cycle -> count stays 16, DROPS unchanged, order preserved.
REQ-034 Reset asserted with 5 descriptors stored -> STATUS reads count 0, empty=1, irq_o=0.
